ucode_sequencer: RTL and testbench

//  Parametrised microcode sequencer for the decode stage. Accepts a program id from decode, walks that

---
 rtl/ucode_pkg.sv | 43 ++++
 rtl/ucode_out_reg.sv | 54 +++++
 rtl/ucode_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ucode_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// ============================================================================
// Module : ucode_pkg
// Brief  : Shared types, program-table field extraction and program-id
//          constants for the microcode sequencer and its decode-side users.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ucode_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ucode_state_e;

  // Widest program table the extract helpers accept
  localparam int unsigned TBL_MAX_W = 4096;

  localparam int unsigned UC_PID_NOP     = 0;
  localparam int unsigned UC_PID_RESET   = 1;
  localparam int unsigned UC_PID_DIV     = 2;
  localparam int unsigned UC_PID_STRCOPY = 3;

  function automatic int unsigned prog_w(input int unsigned num_prog);
    return (num_prog < 2) ? 1 : $clog2(num_prog);
  endfunction

  // Each entry is {offset, len_m1}, program 0 in the LSBs
  function automatic logic [31:0] tbl_offset(input logic [TBL_MAX_W-1:0] tbl,
                                             input int unsigned addr_w,
                                             input int unsigned prog);
    return 32'(tbl >> (prog * 2 * addr_w + addr_w)) & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tbl_len_m1(input logic [TBL_MAX_W-1:0] tbl,
                                             input int unsigned addr_w,
                                             input int unsigned prog);
    return 32'(tbl >> (prog * 2 * addr_w)) & ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ucode_out_reg.sv
// ============================================================================
// Module : ucode_out_reg
// Brief  : Single-entry valid/ready output register (data + last) with flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ucode_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_slot_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      // Word drained (or slot already empty) and nothing new to show
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_last      = r_last;
  assign o_slot_free = ~r_valid | i_ready;

endmodule

`default_nettype wire

// File: rtl/ucode_sequencer.sv
// ============================================================================
// Module : ucode_sequencer
// Brief  : Walks a micro-program out of an async ROM and emits one registered
//          micro-op per cycle on a valid/ready port. UCODE_REPEAT_EN enables
//          multi-pass programs via i_rep_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int unsigned                    NUM_PROG   = 8,
  parameter int unsigned                    ADDR_W     = 5,
  parameter int unsigned                    WORD_W     = 128,
  parameter logic [NUM_PROG*2*ADDR_W-1:0]   PROG_TABLE = '0,
  parameter int unsigned                    REP_W      = 16,
  localparam int unsigned                   PROG_W     = prog_w(NUM_PROG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_prog_valid,
  output logic              o_prog_ready,
  input  logic [PROG_W-1:0] i_prog_id,
  input  logic [REP_W-1:0]  i_rep_count,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WORD_W-1:0] i_rom_data,
  output logic              o_uop_valid,
  input  logic              i_uop_ready,
  output logic [WORD_W-1:0] o_uop_word,
  output logic              o_uop_last,
  output logic [PROG_W-1:0] o_uop_prog,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [TBL_MAX_W-1:0] C_TBL = TBL_MAX_W'(PROG_TABLE);

  ucode_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_count, w_count_nxt;
  logic [PROG_W-1:0] r_prog,  w_prog_nxt;

  logic [ADDR_W-1:0] w_off_tbl [NUM_PROG];
  logic [ADDR_W-1:0] w_len_tbl [NUM_PROG];
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_len_m1;

  logic              w_slot_free;
  logic              w_load;
  logic              w_end_of_pass;
  logic              w_more_passes;
  logic              w_final_word;
  logic [WORD_W+PROG_W-1:0] w_out_data;

  for (genvar p = 0; p < NUM_PROG; p++) begin : g_tbl
    assign w_off_tbl[p] = ADDR_W'(tbl_offset(C_TBL, ADDR_W, p));
    assign w_len_tbl[p] = ADDR_W'(tbl_len_m1(C_TBL, ADDR_W, p));
  end

  assign w_off    = w_off_tbl[r_prog];
  assign w_len_m1 = w_len_tbl[r_prog];

  // Address wraps modulo 2^ADDR_W by construction
  assign o_rom_addr = w_off + r_count;

`ifdef UCODE_REPEAT_EN
  logic [REP_W-1:0] r_pass, w_pass_nxt;

  assign w_more_passes = (r_pass != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= '0;
    end else begin
      r_pass <= w_pass_nxt;
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep  = ^i_rep_count;
  assign w_more_passes = 1'b0;
`endif

  assign o_prog_ready  = (r_state == ST_IDLE) & ~i_flush;
  assign w_end_of_pass = (r_count == w_len_m1);
  assign w_final_word  = w_end_of_pass & ~w_more_passes;
  assign w_load        = (r_state == ST_RUN) & w_slot_free & ~i_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_prog_nxt  = r_prog;
`ifdef UCODE_REPEAT_EN
    w_pass_nxt  = r_pass;
`endif
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_prog_valid) begin
            w_prog_nxt  = i_prog_id;
            w_count_nxt = '0;
            w_state_nxt = ST_RUN;
`ifdef UCODE_REPEAT_EN
            w_pass_nxt  = i_rep_count;
`endif
          end
        end
        ST_RUN: begin
          if (w_slot_free) begin
            if (!w_end_of_pass) begin
              w_count_nxt = r_count + ADDR_W'(1);
            end else if (w_more_passes) begin
              w_count_nxt = '0;
`ifdef UCODE_REPEAT_EN
              w_pass_nxt  = r_pass - REP_W'(1);
`endif
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_prog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_prog  <= w_prog_nxt;
    end
  end

  ucode_out_reg #(
    .DATA_W (WORD_W + PROG_W)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_load      (w_load),
    .i_data      ({i_rom_data, r_prog}),
    .i_last      (w_final_word),
    .i_ready     (i_uop_ready),
    .o_valid     (o_uop_valid),
    .o_data      (w_out_data),
    .o_last      (o_uop_last),
    .o_slot_free (w_slot_free)
  );

  assign o_uop_word = w_out_data[WORD_W+PROG_W-1:PROG_W];
  assign o_uop_prog = w_out_data[PROG_W-1:0];

  // A flushed last word never reports completion
  assign o_done = o_uop_valid & i_uop_ready & o_uop_last & ~i_flush;
  assign o_busy = (r_state == ST_RUN) | o_uop_valid;

endmodule

`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
// ============================================================================
// Module : tb_ucode_sequencer
// Brief  : Directed vector tables plus randomized traffic against a queue
//          based reference model of the microcode sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ucode_sequencer;

  // Programs p0..p7 as {offset, len_m1}, p0 in the LSBs
  localparam logic [79:0] TB_TABLE = {
    5'd31, 5'd31,  5'd20, 5'd10,  5'd16, 5'd2,   5'd28, 5'd6,
    5'd4,  5'd4,   5'd8,  5'd7,   5'd1,  5'd2,   5'd0,  5'd0
  };
  localparam int M_OFF [8] = '{0, 1, 8, 4, 28, 16, 20, 31};
  localparam int M_LEN [8] = '{0, 2, 7, 4, 6, 2, 10, 31};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fl, pv, rdy;
  logic [2:0]  id;
  logic [15:0] rep;
  logic        o_prog_ready, o_uop_valid, o_uop_last, o_busy, o_done;
  logic [4:0]  o_rom_addr;
  logic [31:0] rom_data, o_uop_word;
  logic [2:0]  o_uop_prog;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [4:0] a);
    return {16'hC0DE, 3'b000, a, a ^ 5'h15, 3'b101};
  endfunction

  assign rom_data = rom_word(o_rom_addr);

  ucode_sequencer #(
    .NUM_PROG   (8),
    .ADDR_W     (5),
    .WORD_W     (32),
    .PROG_TABLE (TB_TABLE),
    .REP_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (fl),
    .i_prog_valid (pv),
    .o_prog_ready (o_prog_ready),
    .i_prog_id    (id),
    .i_rep_count  (rep),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (rom_data),
    .o_uop_valid  (o_uop_valid),
    .i_uop_ready  (rdy),
    .o_uop_word   (o_uop_word),
    .o_uop_last   (o_uop_last),
    .o_uop_prog   (o_uop_prog),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: every requested word is queued up front; m_to_load
  // counts the tail not yet moved into the output register.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] word;
    logic        last;
    logic [2:0]  prog;
  } exp_t;

  exp_t mq[$];
  int   m_to_load;
  bit   m_held;

  task automatic model_reset();
    mq.delete();
    m_to_load = 0;
    m_held    = 1'b0;
  endtask

  task automatic model_step();
    bit idle, slot_free;
    int passes;
    exp_t e;
    if (fl) begin
      model_reset();
    end else begin
      idle      = (m_to_load == 0);
      slot_free = !m_held || rdy;
      if (m_held && rdy) begin
        void'(mq.pop_front());
        m_held = 1'b0;
      end
      if (!idle && slot_free) begin
        m_to_load--;
        m_held = 1'b1;
      end else if (idle && pv) begin
        passes = 1;
`ifdef UCODE_REPEAT_EN
        passes = int'(rep) + 1;
`endif
        for (int ps = 0; ps < passes; ps++) begin
          for (int i = 0; i <= M_LEN[id]; i++) begin
            e.addr = 5'((M_OFF[id] + i) % 32);
            e.word = rom_word(e.addr);
            e.last = (ps == passes - 1) && (i == M_LEN[id]);
            e.prog = id;
            mq.push_back(e);
            m_to_load++;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    bit exp_done;
    chk("m_prog_ready", o_prog_ready, (m_to_load == 0) && !fl);
    chk("m_uop_valid", o_uop_valid, m_held);
    chk("m_busy", o_busy, (m_to_load > 0) || m_held);
    exp_done = m_held && (mq.size() > 0) && rdy && mq[0].last && !fl;
    chk("m_done", o_done, exp_done);
    if (m_held && mq.size() > 0) begin
      chk("m_uop_word", o_uop_word, mq[0].word);
      chk("m_uop_last", o_uop_last, mq[0].last);
      chk("m_uop_prog", o_uop_prog, mq[0].prog);
    end else begin
      chk("m_uop_last_idle", o_uop_last, 1'b0);
    end
    if (m_to_load > 0 && mq.size() >= m_to_load)
      chk("m_rom_addr", o_rom_addr, mq[mq.size() - m_to_load].addr);
  endtask

  task automatic pre_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic post_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       pv;
    logic [2:0] id;
    logic       rdy;
    logic       e_pr;
    logic       e_v;
    logic [4:0] e_waddr;
    logic [2:0] e_prog;
    logic       e_last;
    logic       e_done;
    logic       e_busy;
    logic       chk_addr;
    logic [4:0] e_addr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic a_pv, logic [2:0] a_id, logic a_rdy, logic a_pr, logic a_v,
                              logic [4:0] a_wa, logic [2:0] a_pg, logic a_last, logic a_done,
                              logic a_busy, logic a_ca, logic [4:0] a_addr);
    vec_t v;
    v.pv = a_pv; v.id = a_id; v.rdy = a_rdy; v.e_pr = a_pr; v.e_v = a_v; v.e_waddr = a_wa;
    v.e_prog = a_pg; v.e_last = a_last; v.e_done = a_done; v.e_busy = a_busy;
    v.chk_addr = a_ca; v.e_addr = a_addr;
    return v;
  endfunction

  int n_seen, n_last, last_pos, exp_uops;

  initial begin
    rst_n = 1'b0; fl = 1'b0; pv = 1'b0; rdy = 1'b0; id = '0; rep = '0;
    model_reset();

    // p3 straight through
    vt.push_back(mk(1,3,1, 1,0,0,0,0,0,0, 0,0));
    vt.push_back(mk(0,0,1, 0,0,0,0,0,0,1, 1,4));
    vt.push_back(mk(0,0,1, 0,1,4,3,0,0,1, 1,5));
    vt.push_back(mk(0,0,1, 0,1,5,3,0,0,1, 1,6));
    vt.push_back(mk(0,0,1, 0,1,6,3,0,0,1, 1,7));
    vt.push_back(mk(0,0,1, 0,1,7,3,0,0,1, 1,8));
    vt.push_back(mk(0,0,1, 1,1,8,3,1,1,1, 0,0));
    vt.push_back(mk(0,0,1, 1,0,0,0,0,0,0, 0,0));
    // p3 with downstream stalls on the second word
    vt.push_back(mk(1,3,1, 1,0,0,0,0,0,0, 0,0));
    vt.push_back(mk(0,0,1, 0,0,0,0,0,0,1, 1,4));
    vt.push_back(mk(0,0,1, 0,1,4,3,0,0,1, 1,5));
    vt.push_back(mk(0,0,0, 0,1,5,3,0,0,1, 1,6));
    vt.push_back(mk(0,0,0, 0,1,5,3,0,0,1, 1,6));
    vt.push_back(mk(0,0,1, 0,1,5,3,0,0,1, 1,6));
    vt.push_back(mk(0,0,1, 0,1,6,3,0,0,1, 1,7));
    vt.push_back(mk(0,0,1, 0,1,7,3,0,0,1, 1,8));
    vt.push_back(mk(0,0,1, 1,1,8,3,1,1,1, 0,0));
    vt.push_back(mk(0,0,1, 1,0,0,0,0,0,0, 0,0));
    // single-word p0, then p1 back-to-back
    vt.push_back(mk(1,0,1, 1,0,0,0,0,0,0, 0,0));
    vt.push_back(mk(1,1,1, 0,0,0,0,0,0,1, 1,0));
    vt.push_back(mk(1,1,1, 1,1,0,0,1,1,1, 0,0));
    vt.push_back(mk(0,0,1, 0,0,0,0,0,0,1, 1,1));
    vt.push_back(mk(0,0,1, 0,1,1,1,0,0,1, 1,2));
    vt.push_back(mk(0,0,1, 0,1,2,1,0,0,1, 1,3));
    vt.push_back(mk(0,0,1, 1,1,3,1,1,1,1, 0,0));
    vt.push_back(mk(0,0,1, 1,0,0,0,0,0,0, 0,0));

    @(posedge clk); #1;
    chk("reset_valid", o_uop_valid, 1'b0);
    chk("reset_word",  o_uop_word, 32'h0);
    chk("reset_last",  o_uop_last, 1'b0);
    chk("reset_prog",  o_uop_prog, 3'h0);
    chk("reset_busy",  o_busy, 1'b0);
    chk("reset_done",  o_done, 1'b0);
    rst_n = 1'b1;

    foreach (vt[k]) begin
      pv = vt[k].pv; id = vt[k].id; rdy = vt[k].rdy;
      pre_edge();
      chk($sformatf("tbl%0d_prog_ready", k), o_prog_ready, vt[k].e_pr);
      chk($sformatf("tbl%0d_valid", k), o_uop_valid, vt[k].e_v);
      chk($sformatf("tbl%0d_last", k), o_uop_last, vt[k].e_last);
      chk($sformatf("tbl%0d_done", k), o_done, vt[k].e_done);
      chk($sformatf("tbl%0d_busy", k), o_busy, vt[k].e_busy);
      if (vt[k].e_v) begin
        chk($sformatf("tbl%0d_word", k), o_uop_word, rom_word(vt[k].e_waddr));
        chk($sformatf("tbl%0d_prog", k), o_uop_prog, vt[k].e_prog);
      end
      if (vt[k].chk_addr)
        chk($sformatf("tbl%0d_rom_addr", k), o_rom_addr, vt[k].e_addr);
      post_edge();
    end

    // Flush on the third word of p2 while a new request is offered
    pv = 1'b1; id = 3'd2; rdy = 1'b1;
    pre_edge(); post_edge();
    pv = 1'b0;
    repeat (3) begin pre_edge(); post_edge(); end
    fl = 1'b1; pv = 1'b1; id = 3'd1;
    pre_edge();
    chk("flush_cycle_valid", o_uop_valid, 1'b1);
    chk("flush_cycle_word", o_uop_word, rom_word(5'd10));
    chk("flush_cycle_done", o_done, 1'b0);
    chk("flush_cycle_ready", o_prog_ready, 1'b0);
    post_edge();
    fl = 1'b0; pv = 1'b0;
    pre_edge();
    chk("flush_after_valid", o_uop_valid, 1'b0);
    chk("flush_after_ready", o_prog_ready, 1'b1);
    chk("flush_after_busy", o_busy, 1'b0);
    chk("flush_after_last", o_uop_last, 1'b0);
    post_edge();
    // Request offered during an idle flush must be dropped
    fl = 1'b1; pv = 1'b1; id = 3'd3;
    pre_edge();
    chk("flush_idle_ready", o_prog_ready, 1'b0);
    post_edge();
    fl = 1'b0; pv = 1'b0;
    pre_edge();
    chk("flush_idle_busy", o_busy, 1'b0);
    post_edge();
    pre_edge();
    chk("flush_idle_valid", o_uop_valid, 1'b0);
    post_edge();

    // Asynchronous reset in the middle of p6
    pv = 1'b1; id = 3'd6; rdy = 1'b1;
    pre_edge(); post_edge();
    pv = 1'b0;
    repeat (3) begin pre_edge(); post_edge(); end
    chk("arst_pre_valid", o_uop_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", o_uop_valid, 1'b0);
    chk("arst_word",  o_uop_word, 32'h0);
    chk("arst_last",  o_uop_last, 1'b0);
    chk("arst_prog",  o_uop_prog, 3'h0);
    chk("arst_busy",  o_busy, 1'b0);
    chk("arst_done",  o_done, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    pre_edge();
    chk("arst_release_ready", o_prog_ready, 1'b1);
    post_edge();

    // Multi-pass request (single pass when repeat support is absent)
`ifdef UCODE_REPEAT_EN
    exp_uops = 9;
`else
    exp_uops = 3;
`endif
    pv = 1'b1; id = 3'd5; rep = 16'd2; rdy = 1'b1;
    pre_edge(); post_edge();
    pv = 1'b0; rep = '0;
    n_seen = 0; n_last = 0; last_pos = -1;
    for (int c = 0; c < 40; c++) begin
      pre_edge();
      if (o_uop_valid && rdy) begin
        chk("rep_word", o_uop_word, rom_word(5'(16 + n_seen % 3)));
        if (o_uop_last) begin
          n_last++;
          last_pos = n_seen;
        end
        n_seen++;
      end
      post_edge();
    end
    chk("rep_uop_count", n_seen, exp_uops);
    chk("rep_last_count", n_last, 1);
    chk("rep_last_pos", last_pos, exp_uops - 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      pv  = ($urandom_range(0, 99) < 40);
      id  = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 99) < 75);
      fl  = ($urandom_range(0, 99) < 2);
      rep = 16'($urandom_range(0, 2));
      pre_edge();
      post_edge();
    end
    pv = 1'b0; fl = 1'b0; rdy = 1'b1;
    repeat (120) begin pre_edge(); post_edge(); end
    pre_edge();
    chk("drain_busy", o_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
